// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard unit: forwarding select encoding, default
// register count and the register-address type.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   localparam int HZ_NUM_REGS = 32;

   typedef logic [$clog2(HZ_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard unit bundle. master = pipeline side, slave = hazard unit.
// Optional perf counters appear only when HAZARD_PERF_EN is defined.
interface hazard_scoreboard_if #(
   parameter int NUM_REGS        = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int REG_AW          = $clog2(NUM_REGS),
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
   logic [REG_AW-1:0]   Rs1D, Rs2D, RdD;
   logic                LongOpD;
   logic [REG_AW-1:0]   Rs1E, Rs2E, RdE;
   logic                LoadE, LongIssueE, PCSrcE;
   logic [REG_AW-1:0]   RdM;
   logic                RegWriteM;
   logic [REG_AW-1:0]   RdW;
   logic                RegWriteW, LongDoneW;
   logic                StallF, StallD, FlushD, FlushE;
   logic [1:0]          ForwardAE, ForwardBE;
   logic [NUM_REGS-1:0] Pending;
   logic [CNT_W-1:0]    Outstanding;
`ifdef HAZARD_PERF_EN
   logic [31:0]         PerfLoadStall, PerfSbStall, PerfFlush;
`endif

   modport master (
      output Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, LoadE, LongIssueE, PCSrcE,
             RdM, RegWriteM, RdW, RegWriteW, LongDoneW,
`ifdef HAZARD_PERF_EN
      input  PerfLoadStall, PerfSbStall, PerfFlush,
`endif
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, Pending, Outstanding
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, LongOpD, Rs1E, Rs2E, RdE, LoadE, LongIssueE, PCSrcE,
             RdM, RegWriteM, RdW, RegWriteW, LongDoneW,
`ifdef HAZARD_PERF_EN
      output PerfLoadStall, PerfSbStall, PerfFlush,
`endif
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, Pending, Outstanding
   );
endinterface

// File: rtl/hazard_scoreboard_regs.sv
// Register scoreboard for long (MUL/DIV) ops: per-register pending bits,
// outstanding-op counter, and the "effective pending" view used for stalls.
module scoreboard_regs #(
   parameter int NUM_REGS        = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int REG_AW          = $clog2(NUM_REGS),
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_issue,
   input  logic [REG_AW-1:0]   i_rd_issue,
   input  logic                i_done,
   input  logic [REG_AW-1:0]   i_rd_done,
   output logic [NUM_REGS-1:0] o_pending,
   output logic [NUM_REGS-1:0] o_eff_pend,
   output logic [CNT_W-1:0]    o_outstanding
);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_pend_nxt;
   logic [NUM_REGS-1:0] w_done_mask;
   logic [CNT_W-1:0]    r_cnt;
   logic                w_set;

   // x0 never becomes pending, so a long op targeting x0 only counts as outstanding
   assign w_set = i_issue && (i_rd_issue != '0);

   // a register finishing this cycle is written on the falling edge, so it is already free
   assign w_done_mask = i_done ? (NUM_REGS'(1) << i_rd_done) : '0;
   assign o_eff_pend  = r_pending & ~w_done_mask;

   // next pending: clear first, then set, so a younger op on the same register wins
   always_comb begin
      w_pend_nxt = r_pending;
      if (i_done) w_pend_nxt[i_rd_done] = 1'b0;
      if (w_set)  w_pend_nxt[i_rd_issue] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   // pending bit register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_pend_nxt;
   end

   // outstanding counter, saturating at both ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else begin
         case ({i_issue, i_done})
            2'b10:   if (r_cnt != MAX_CNT) r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   if (r_cnt != '0)      r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_pending     = r_pending;
   assign o_outstanding = r_cnt;

   // pushing past either counter bound means the pipeline broke the protocol
   a_cnt_ovf: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_issue && !i_done && r_cnt == MAX_CNT))
      else $error("scoreboard: long-op issue with counter already at max");
   a_cnt_udf: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_done && !i_issue && r_cnt == '0))
      else $error("scoreboard: long-op completion with no op outstanding");
   a_stray_done: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_done && !r_pending[i_rd_done]))
      else $warning("scoreboard: completion for a register that is not pending");

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32 pipeline: M/W forwarding, load-use stall,
// branch flush and per-register RAW/WAW/capacity stalls for long ops.
// Optional: define HAZARD_PERF_EN to add load/scoreboard/flush perf counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS        = HZ_NUM_REGS,
   parameter int MAX_OUTSTANDING = 4,
   parameter int REG_AW          = $clog2(NUM_REGS),
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input logic                clk,
   input logic                rst_n,
   hazard_scoreboard_if.slave bus
);
   logic [NUM_REGS-1:0] w_pending, w_eff_pend;
   logic [CNT_W-1:0]    w_outstanding;
   logic                w_lw_stall, w_sb_stall, w_full;
   fwd_sel_e            w_fwd_a, w_fwd_b;

   function automatic fwd_sel_e fwd_pick(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rd_m,
      input logic              we_m,
      input logic [REG_AW-1:0] rd_w,
      input logic              we_w
   );
      if (rs != '0 && we_m && rs == rd_m) return FWD_M;
      if (rs != '0 && we_w && rs == rd_w) return FWD_W;
      return FWD_RF;
   endfunction

   scoreboard_regs #(
      .NUM_REGS        (NUM_REGS),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .REG_AW          (REG_AW),
      .CNT_W           (CNT_W)
   ) u_sb (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_issue       (bus.LongIssueE),
      .i_rd_issue    (bus.RdE),
      .i_done        (bus.LongDoneW),
      .i_rd_done     (bus.RdW),
      .o_pending     (w_pending),
      .o_eff_pend    (w_eff_pend),
      .o_outstanding (w_outstanding)
   );

   assign w_fwd_a = fwd_pick(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
   assign w_fwd_b = fwd_pick(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);

   assign w_lw_stall = bus.LoadE && (bus.RdE != '0) &&
                       ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));

   // a completion in the same cycle frees a slot, so it does not block a new long op
   assign w_full = (w_outstanding == CNT_W'(MAX_OUTSTANDING)) && !bus.LongDoneW;

   // eff_pend[0] is always 0, so the RAW terms need no explicit x0 guard
   assign w_sb_stall = w_eff_pend[bus.Rs1D] || w_eff_pend[bus.Rs2D] ||
                       (w_eff_pend[bus.RdD] && bus.RdD != '0) ||
                       (bus.LongOpD && w_full);

   assign bus.StallF      = w_lw_stall | w_sb_stall;
   assign bus.StallD      = w_lw_stall | w_sb_stall;
   assign bus.FlushD      = bus.PCSrcE;
   assign bus.FlushE      = w_lw_stall | w_sb_stall | bus.PCSrcE;
   assign bus.ForwardAE   = w_fwd_a;
   assign bus.ForwardBE   = w_fwd_b;
   assign bus.Pending     = w_pending;
   assign bus.Outstanding = w_outstanding;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_ld, r_perf_sb, r_perf_fl;

   // event counters; wrap naturally at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_ld <= '0;
         r_perf_sb <= '0;
         r_perf_fl <= '0;
      end else begin
         if (w_lw_stall)                r_perf_ld <= r_perf_ld + 32'd1;
         if (w_sb_stall && !w_lw_stall) r_perf_sb <= r_perf_sb + 32'd1;
         if (bus.PCSrcE)                r_perf_fl <= r_perf_fl + 32'd1;
      end
   end

   assign bus.PerfLoadStall = r_perf_ld;
   assign bus.PerfSbStall   = r_perf_sb;
   assign bus.PerfFlush     = r_perf_fl;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expected outputs are queued when
// stimulus is applied and compared at the following falling edge.
module tb_hazard_scoreboard;
   localparam int NR = 32;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.NUM_REGS(NR), .MAX_OUTSTANDING(MO)) hz();

   hazard_scoreboard #(.NUM_REGS(NR), .MAX_OUTSTANDING(MO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (hz)
   );

   typedef struct {
      string       tag;
      int          fld;
      logic [63:0] val;
   } exp_t;

   exp_t        q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [NR-1:0] m_pend;
   int          m_out;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [63:0] get_f(input int id);
      case (id)
         0: return 64'(hz.StallF);
         1: return 64'(hz.StallD);
         2: return 64'(hz.FlushD);
         3: return 64'(hz.FlushE);
         4: return 64'(hz.ForwardAE);
         5: return 64'(hz.ForwardBE);
         6: return 64'(hz.Pending);
         7: return 64'(hz.Outstanding);
         8: return 64'(hz.Pending[9]);
         default: return 'x;
      endcase
   endfunction

   task automatic push(input string tag, input int fld, input logic [63:0] v);
      exp_t e;
      e.tag = tag; e.fld = fld; e.val = v;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.tag, get_f(e.fld), e.val);
      end
   endtask

   function automatic logic [1:0] mfwd(input logic [4:0] rs);
      if (rs != 0 && hz.RegWriteM && rs == hz.RdM) return 2'b10;
      if (rs != 0 && hz.RegWriteW && rs == hz.RdW) return 2'b01;
      return 2'b00;
   endfunction

   // reference outputs from the bench's own scoreboard state and current inputs
   task automatic push_model(input string tag);
      logic [NR-1:0] effp;
      logic lw, sb, st;
      effp = m_pend;
      if (hz.LongDoneW) effp[hz.RdW] = 1'b0;
      lw = hz.LoadE && hz.RdE != 0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
      sb = effp[hz.Rs1D] || effp[hz.Rs2D] || (hz.RdD != 0 && effp[hz.RdD]) ||
           (hz.LongOpD && m_out == MO && !hz.LongDoneW);
      st = lw || sb;
      push({tag, "/StallF"}, 0, 64'(st));
      push({tag, "/StallD"}, 1, 64'(st));
      push({tag, "/FlushD"}, 2, 64'(hz.PCSrcE));
      push({tag, "/FlushE"}, 3, 64'(st || hz.PCSrcE));
      push({tag, "/FwdA"},   4, 64'(mfwd(hz.Rs1E)));
      push({tag, "/FwdB"},   5, 64'(mfwd(hz.Rs2E)));
      push({tag, "/Pend"},   6, 64'(m_pend));
      push({tag, "/Outst"},  7, 64'(m_out));
   endtask

   task automatic model_update();
      if (hz.LongDoneW) m_pend[hz.RdW] = 1'b0;
      if (hz.LongIssueE && hz.RdE != 0) m_pend[hz.RdE] = 1'b1;
      if (hz.LongIssueE && !hz.LongDoneW && m_out < MO) m_out++;
      else if (hz.LongDoneW && !hz.LongIssueE && m_out > 0) m_out--;
   endtask

   task automatic idle();
      hz.Rs1D = 0; hz.Rs2D = 0; hz.RdD = 0; hz.LongOpD = 0;
      hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0; hz.LoadE = 0;
      hz.LongIssueE = 0; hz.PCSrcE = 0;
      hz.RdM = 0; hz.RegWriteM = 0; hz.RdW = 0; hz.RegWriteW = 0; hz.LongDoneW = 0;
   endtask

   // one cycle: queue model expectations, compare at negedge, advance at posedge
   task automatic cyc(input string tag);
      push_model(tag);
      @(negedge clk);
      drain();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic issue(input int rd);
      idle(); hz.LongIssueE = 1; hz.RdE = 5'(rd);
      cyc("issue");
   endtask

   initial begin
      rst_n = 1'b0; idle(); m_pend = '0; m_out = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) push("reset", i, 64'd0);
      drain();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // forwarding priority
      idle(); hz.RdM = 5; hz.RdW = 5; hz.Rs1E = 5; hz.RegWriteM = 1; hz.RegWriteW = 1;
      push("fwd_m", 4, 64'd2); cyc("fwd_m");
      hz.RegWriteM = 0; hz.Rs2E = 5;
      push("fwd_w", 4, 64'd1); push("fwd_wb", 5, 64'd1); cyc("fwd_w");
      hz.Rs1E = 0;
      push("fwd_x0", 4, 64'd0); cyc("fwd_x0");

      // load-use
      idle(); hz.LoadE = 1; hz.RdE = 7; hz.Rs2D = 7;
      push("lw_stF", 0, 64'd1); push("lw_stD", 1, 64'd1); push("lw_flE", 3, 64'd1);
      push("lw_flD", 2, 64'd0); cyc("lw");
      idle(); push("lw_gone", 0, 64'd0); cyc("lw_gone");
      hz.LoadE = 1; hz.RdE = 0;
      push("lw_x0", 0, 64'd0); cyc("lw_x0");

      // long-op RAW
      issue(3);
      idle(); hz.Rs1D = 3;
      push("raw_pend", 6, 64'h8); push("raw_out", 7, 64'd1); push("raw_st", 1, 64'd1);
      cyc("raw1");
      cyc("raw2");
      hz.LongDoneW = 1; hz.RdW = 3; hz.RegWriteW = 1;
      push("raw_rel", 1, 64'd0); push("raw_relE", 3, 64'd0); cyc("raw_done");
      idle(); push("raw_clr", 6, 64'd0); push("raw_out0", 7, 64'd0); cyc("raw_after");

      // independent instruction, then WAW
      issue(3);
      idle(); hz.Rs1D = 4; hz.Rs2D = 5; hz.RdD = 6;
      push("indep", 1, 64'd0); push("indep_p", 6, 64'h8); cyc("indep");
      hz.RdD = 3; push("waw", 1, 64'd1); cyc("waw");

      // capacity
      issue(10); issue(11); issue(12);
      idle(); hz.LongOpD = 1;
      push("cap_out", 7, 64'd4); push("cap_st", 0, 64'd1); cyc("cap");
      hz.LongDoneW = 1; hz.RdW = 10;
      push("cap_rel", 0, 64'd0); cyc("cap_rel");

      // simultaneous set/clear on reg 9
      issue(9);
      idle(); hz.LongIssueE = 1; hz.RdE = 9; hz.LongDoneW = 1; hz.RdW = 9;
      cyc("setclr");
      idle(); push("setclr_p9", 8, 64'd1); push("setclr_out", 7, 64'd4); cyc("setclr_after");

      // asynchronous reset mid-flight
      idle(); hz.Rs1D = 3;
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      m_pend = '0; m_out = 0;
      hz.PCSrcE = 1; #1;
      push("arst_p", 6, 64'd0); push("arst_o", 7, 64'd0); push("arst_flD", 2, 64'd1);
      push("arst_flE", 3, 64'd1); push("arst_st", 1, 64'd0);
      drain();
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // branch flush
      idle(); hz.PCSrcE = 1;
      push("br_flD", 2, 64'd1); push("br_flE", 3, 64'd1); push("br_st", 0, 64'd0);
      cyc("branch");

      // constrained random traffic against the model
      for (int k = 0; k < 60; k++) begin
         int r;
         idle();
         hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
         hz.RdD  = 5'($urandom_range(0, 7)); hz.LongOpD = 1'($urandom_range(0, 1));
         hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
         hz.RdE  = 5'($urandom_range(0, 7)); hz.LoadE = ($urandom_range(0, 3) == 0);
         hz.PCSrcE = ($urandom_range(0, 3) == 0);
         hz.RdM = 5'($urandom_range(0, 7)); hz.RegWriteM = 1'($urandom_range(0, 1));
         r = $urandom_range(1, 7);
         hz.RdW = 5'(r); hz.RegWriteW = 1'($urandom_range(0, 1));
         hz.LongDoneW = m_pend[r] && ($urandom_range(0, 1) == 1);
         hz.LongIssueE = ($urandom_range(0, 2) == 0) && (m_out < MO || hz.LongDoneW);
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
